// File: rtl/frame_bank_scheduler_if.sv
// Bus bundle between the frame bank scheduler and its environment: pixel
// stream, the four frame banks, the flow-engine pair handshake and the read port.
interface frame_bank_scheduler_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0]   pixel_data;
  logic                pixel_valid;
  logic [3:0]          bank_ce;
  logic [3:0]          bank_wre;
  logic [4*ADDR_W-1:0] bank_ad;
  logic [DATA_W-1:0]   bank_din;
  logic [4*DATA_W-1:0] bank_dout;
  logic                pair_ready;
  logic                pair_start;
  logic                pair_done;
  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ready;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_prev;
  logic [DATA_W-1:0]   rd_curr;
  logic                frame_drop;
  logic [7:0]          drop_cnt;

  // Scheduler side
  modport slave (
    input  pixel_data, pixel_valid, bank_dout, pair_start, pair_done, rd_req, rd_addr,
    output bank_ce, bank_wre, bank_ad, bank_din, pair_ready, rd_ready, rd_valid,
           rd_prev, rd_curr, frame_drop, drop_cnt
  );

  // Environment side (pixel source, banks, flow engine)
  modport master (
    output pixel_data, pixel_valid, bank_dout, pair_start, pair_done, rd_req, rd_addr,
    input  bank_ce, bank_wre, bank_ad, bank_din, pair_ready, rd_ready, rd_valid,
           rd_prev, rd_curr, frame_drop, drop_cnt
  );
endinterface

// File: rtl/frame_bank_scheduler.sv
// Frame bank scheduler: rotates the pixel writer over four single-port banks,
// publishes finished frames, locks the two newest adjacent frames for the flow
// engine and serves their pixels as an aligned pair with two-cycle latency.
module frame_bank_scheduler #(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned FRAME_PIXELS = 16384,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  frame_bank_scheduler_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} rd_state_e;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);

  rd_state_e         state_q, state_d;
  logic [1:0]        wp_q, wp_d;
  logic [1:0]        latest_q, latest_d;
  logic [1:0]        prev_q, prev_d;
  logic [1:0]        curr_q, curr_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [1:0]        valid_frames_q, valid_frames_d;
  logic              fresh_q, fresh_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              frame_drop_q, frame_drop_d;

  logic              rd_s1_q;
  logic [1:0]        rd_s1_prev_q, rd_s1_curr_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_prev_q, rd_curr_q;

  logic              wr_en, rd_en, frame_end, next_locked, publish, drop;
  logic              pair_ready, start;
  logic [1:0]        next_bank;
  logic [DATA_W-1:0] dout_prev, dout_curr;
  logic [3:0]        ce_c, wre_c;
  logic [4*ADDR_W-1:0] ad_c;

  // Frame bookkeeping, drop decision and reader FSM next state
  always_comb begin
    wr_en       = bus.pixel_valid & reset;
    rd_en       = bus.rd_req & (state_q == BUSY);
    frame_end   = wr_en && (pix_cnt_q == LAST_PIX);
    next_bank   = wp_q + 2'd1;
    // A pair_done in the same cycle frees the locks before the check
    next_locked = (state_q == BUSY) && !bus.pair_done &&
                  ((next_bank == prev_q) || (next_bank == curr_q));
    publish     = frame_end && !next_locked;
    drop        = frame_end && next_locked;
    pair_ready  = (state_q == IDLE) && (valid_frames_q == 2'd2) && fresh_q;
    start       = pair_ready && bus.pair_start;

    state_d        = state_q;
    wp_d           = wp_q;
    latest_d       = latest_q;
    prev_d         = prev_q;
    curr_d         = curr_q;
    pix_cnt_d      = pix_cnt_q;
    valid_frames_d = valid_frames_q;
    fresh_d        = fresh_q;
    drop_cnt_d     = drop_cnt_q;
    frame_drop_d   = drop;

    if (wr_en) pix_cnt_d = frame_end ? '0 : pix_cnt_q + ADDR_W'(1);

    if (publish) begin
      latest_d       = wp_q;
      valid_frames_d = (valid_frames_q == 2'd2) ? 2'd2 : valid_frames_q + 2'd1;
      fresh_d        = 1'b1;
      wp_d           = next_bank;
    end
    if (drop) begin
      valid_frames_d = '0;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE: if (start) begin
        // Pair latched from pre-publish state; a simultaneous publish keeps fresh
        state_d = BUSY;
        curr_d  = latest_q;
        prev_d  = latest_q - 2'd1;
        if (!publish) fresh_d = 1'b0;
      end
      BUSY: if (bus.pair_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      wp_q           <= '0;
      latest_q       <= '0;
      prev_q         <= '0;
      curr_q         <= '0;
      pix_cnt_q      <= '0;
      valid_frames_q <= '0;
      fresh_q        <= 1'b0;
      drop_cnt_q     <= '0;
      frame_drop_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wp_q           <= wp_d;
      latest_q       <= latest_d;
      prev_q         <= prev_d;
      curr_q         <= curr_d;
      pix_cnt_q      <= pix_cnt_d;
      valid_frames_q <= valid_frames_d;
      fresh_q        <= fresh_d;
      drop_cnt_q     <= drop_cnt_d;
      frame_drop_q   <= frame_drop_d;
    end
  end

  // Bank port steering: write bank and locked read banks never coincide
  always_comb begin
    ce_c  = '0;
    wre_c = '0;
    ad_c  = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_en && (wp_q == b[1:0])) begin
        ce_c[b]                  = 1'b1;
        wre_c[b]                 = 1'b1;
        ad_c[b*ADDR_W +: ADDR_W] = pix_cnt_q;
      end
      if (rd_en && ((prev_q == b[1:0]) || (curr_q == b[1:0]))) begin
        ce_c[b]                  = 1'b1;
        ad_c[b*ADDR_W +: ADDR_W] = bus.rd_addr;
      end
    end
  end

  // Select the bank outputs belonging to the read issued last cycle
  always_comb begin
    dout_prev = '0;
    dout_curr = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (rd_s1_prev_q == b[1:0]) dout_prev = bus.bank_dout[b*DATA_W +: DATA_W];
      if (rd_s1_curr_q == b[1:0]) dout_curr = bus.bank_dout[b*DATA_W +: DATA_W];
    end
  end

  // Read pipeline; bank indices travel with each request so in-flight reads
  // survive a pair_done / new pair_start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_s1_q      <= 1'b0;
      rd_s1_prev_q <= '0;
      rd_s1_curr_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_prev_q    <= '0;
      rd_curr_q    <= '0;
    end else begin
      rd_s1_q    <= rd_en;
      rd_valid_q <= rd_s1_q;
      if (rd_en) begin
        rd_s1_prev_q <= prev_q;
        rd_s1_curr_q <= curr_q;
      end
      if (rd_s1_q) begin
        rd_prev_q <= dout_prev;
        rd_curr_q <= dout_curr;
      end
    end
  end

  assign bus.bank_ce    = ce_c;
  assign bus.bank_wre   = wre_c;
  assign bus.bank_ad    = ad_c;
  assign bus.bank_din   = bus.pixel_data;
  assign bus.pair_ready = pair_ready;
  assign bus.rd_ready   = (state_q == BUSY);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_prev    = rd_prev_q;
  assign bus.rd_curr    = rd_curr_q;
  assign bus.frame_drop = frame_drop_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: bank memories, a rule-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_frame_bank_scheduler;
  localparam int unsigned AW = 5;
  localparam int unsigned FP = 24;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_bank_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_bank_scheduler #(.ADDR_W(AW), .FRAME_PIXELS(FP), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pv(input int f, input int a);
    return 8'((f * 16 + a * 3 + 7) & 255);
  endfunction

  // Four single-port banks, one-cycle registered read
  logic [DW-1:0] bmem [4][1<<AW];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.bank_ce[b]) begin
        if (bus.bank_wre[b]) bmem[b][bus.bank_ad[b*AW +: AW]] <= bus.bank_din;
        else bus.bank_dout[b*DW +: DW] <= bmem[b][bus.bank_ad[b*AW +: AW]];
      end
    end
  end

  // Reference model
  typedef struct { int due; logic [7:0] p; logic [7:0] c; } rd_t;
  rd_t rq[$];
  int m_wp = 0, m_pix = 0, m_vf = 0, m_latest = 0, m_prev = 0, m_curr = 0, m_drops = 0, m_cyc = 0;
  bit m_fresh = 0, m_busy = 0, m_drop_pulse = 0, m_rdv = 0;
  logic [7:0] m_rdp = '0, m_rdc = '0;
  logic [DW-1:0] m_mem [4][1<<AW];
  bit mr_ready, mr_start, mr_pub, mr_locked;
  int mr_nb, mr_old_latest;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wp = 0; m_pix = 0; m_vf = 0; m_latest = 0; m_prev = 0; m_curr = 0; m_drops = 0;
      m_fresh = 0; m_busy = 0; m_drop_pulse = 0; m_rdv = 0; m_rdp = '0; m_rdc = '0;
      rq.delete();
    end else begin
      mr_ready = !m_busy && m_vf == 2 && m_fresh;
      mr_start = mr_ready && bus.pair_start;
      mr_old_latest = m_latest;
      mr_pub = 0;
      m_drop_pulse = 0;
      if (m_busy && bus.rd_req)
        rq.push_back('{m_cyc + 2, m_mem[m_prev][bus.rd_addr], m_mem[m_curr][bus.rd_addr]});
      if (bus.pixel_valid) begin
        m_mem[m_wp][m_pix] = bus.pixel_data;
        if (m_pix == FP - 1) begin
          m_pix = 0;
          mr_nb = (m_wp + 1) % 4;
          mr_locked = m_busy && !bus.pair_done && (mr_nb == m_prev || mr_nb == m_curr);
          if (mr_locked) begin
            m_vf = 0;
            m_drop_pulse = 1;
            if (m_drops < 255) m_drops++;
          end else begin
            m_latest = m_wp;
            m_vf = (m_vf < 2) ? m_vf + 1 : 2;
            m_fresh = 1;
            m_wp = mr_nb;
            mr_pub = 1;
          end
        end else m_pix++;
      end
      if (mr_start) begin
        m_busy = 1;
        m_curr = mr_old_latest;
        m_prev = (mr_old_latest + 3) % 4;
        m_fresh = mr_pub;
      end else if (m_busy && bus.pair_done) m_busy = 0;
      m_cyc++;
      m_rdv = 0;
      if (rq.size() > 0 && rq[0].due == m_cyc) begin
        m_rdv = 1;
        m_rdp = rq[0].p;
        m_rdc = rq[0].c;
        void'(rq.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model
  logic [3:0] e_ce, e_wre;
  logic [4*AW-1:0] e_ad;
  always @(negedge clk) begin
    e_ce = '0; e_wre = '0; e_ad = '0;
    if (reset && bus.pixel_valid) begin
      e_ce[m_wp] = 1'b1; e_wre[m_wp] = 1'b1; e_ad[m_wp*AW +: AW] = AW'(m_pix);
    end
    if (m_busy && bus.rd_req) begin
      e_ce[m_prev] = 1'b1; e_ce[m_curr] = 1'b1;
      e_ad[m_prev*AW +: AW] = bus.rd_addr; e_ad[m_curr*AW +: AW] = bus.rd_addr;
    end
    chk("bank_ce", bus.bank_ce, e_ce);
    chk("bank_wre", bus.bank_wre, e_wre);
    chk("bank_ad", bus.bank_ad, e_ad);
    chk("bank_din", bus.bank_din, bus.pixel_data);
    chk("pair_ready", bus.pair_ready, !m_busy && m_vf == 2 && m_fresh);
    chk("rd_ready", bus.rd_ready, m_busy);
    chk("rd_valid", bus.rd_valid, m_rdv);
    chk("rd_prev", bus.rd_prev, m_rdp);
    chk("rd_curr", bus.rd_curr, m_rdc);
    chk("frame_drop", bus.frame_drop, m_drop_pulse);
    chk("drop_cnt", bus.drop_cnt, m_drops);
    if (m_busy) chk("wre_on_locked", bus.bank_wre[m_prev] | bus.bank_wre[m_curr], 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f, input bit done_last);
    for (int a = 0; a < int'(FP); a++) begin
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = pv(f, a);
      bus.pair_done   = done_last && (a == int'(FP) - 1);
      tick();
    end
    bus.pixel_valid = 1'b0;
    bus.pair_done   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.pair_start = 1'b1;
    tick();
    bus.pair_start = 1'b0;
  endtask

  task automatic first_pixel_check(input string nm, input logic [3:0] exp_ce, input int f);
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = pv(f, 0);
    #1;
    chk({nm, "_ce"}, bus.bank_ce, exp_ce);
  endtask

  task automatic release_reset();
    bus.pixel_valid = 0; bus.pixel_data = '0; bus.pair_start = 0; bus.pair_done = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int v_cnt, v_first, v_last;

  initial begin
    bus.pixel_valid = 0; bus.pixel_data = '0; bus.pair_start = 0; bus.pair_done = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    tick(); tick();
    chk("rst_pair_ready", bus.pair_ready, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    release_reset();

    // Two frames into banks 0,1 then pair read at address 5
    first_pixel_check("first_after_reset", 4'b0001, 0);
    chk("first_after_reset_ad", bus.bank_ad, 0);
    send_frame(0, 0);
    chk("one_frame_not_ready", bus.pair_ready, 0);
    send_frame(1, 0);
    chk("two_frames_ready", bus.pair_ready, 1);
    pulse_start();
    chk("busy_rd_ready", bus.rd_ready, 1);
    chk("busy_not_ready", bus.pair_ready, 0);
    bus.rd_req = 1; bus.rd_addr = 5'd5;
    tick();
    bus.rd_req = 0;
    chk("lat_n1_invalid", bus.rd_valid, 0);
    tick();
    chk("lat_n2_valid", bus.rd_valid, 1);
    chk("addr5_prev", bus.rd_prev, 8'd22);
    chk("addr5_curr", bus.rd_curr, 8'd38);

    // Frames into banks 2 and 3; the bank-3 frame is dropped
    send_frame(2, 0);
    send_frame(3, 0);
    chk("drop_pulse", bus.frame_drop, 1);
    chk("drop_cnt_1", bus.drop_cnt, 1);
    chk("drop_not_ready", bus.pair_ready, 0);
    first_pixel_check("wp_stays_3", 4'b1000, 4);

    // Same frame end with pair_done: no drop, publish bank 3
    send_frame(4, 1);
    chk("no_drop_pulse", bus.frame_drop, 0);
    chk("no_drop_cnt", bus.drop_cnt, 1);
    chk("released", bus.rd_ready, 0);
    first_pixel_check("wp_wrapped_0", 4'b0001, 5);
    send_frame(5, 0);
    chk("pair_3_0_ready", bus.pair_ready, 1);
    pulse_start();

    // Back-to-back reads 0..15 while frame 6 streams into bank 1
    v_cnt = 0; v_first = -1; v_last = -1;
    for (int i = 0; i < 26; i++) begin
      bus.pixel_valid = (i < int'(FP));
      bus.pixel_data  = pv(6, i);
      bus.rd_req      = (i < 16);
      bus.rd_addr     = AW'(i);
      tick();
      if (bus.rd_valid) begin
        if (v_first < 0) begin
          v_first = i;
          chk("burst_first_prev", bus.rd_prev, 8'd71);
          chk("burst_first_curr", bus.rd_curr, 8'd87);
        end
        v_last = i;
        v_cnt++;
      end
    end
    bus.pixel_valid = 0; bus.rd_req = 0;
    chk("burst_count", v_cnt, 16);
    chk("burst_contiguous", v_last - v_first, 15);

    // Reset mid-frame while BUSY
    bus.pair_done = 1; tick(); bus.pair_done = 0;
    chk("pair_0_1_ready", bus.pair_ready, 1);
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      bus.pixel_valid = 1; bus.pixel_data = pv(7, i);
      bus.rd_req = 1; bus.rd_addr = AW'(i);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ce", bus.bank_ce, 0);
    chk("mid_rst_wre", bus.bank_wre, 0);
    chk("mid_rst_ad", bus.bank_ad, 0);
    chk("mid_rst_rd_ready", bus.rd_ready, 0);
    chk("mid_rst_rd_valid", bus.rd_valid, 0);
    chk("mid_rst_rd_prev", bus.rd_prev, 0);
    chk("mid_rst_rd_curr", bus.rd_curr, 0);
    chk("mid_rst_drop_cnt", bus.drop_cnt, 0);
    chk("mid_rst_pair_ready", bus.pair_ready, 0);
    release_reset();
    first_pixel_check("post_rst", 4'b0001, 0);
    chk("post_rst_ad", bus.bank_ad, 0);

    // Drop-counter saturation
    send_frame(0, 0);
    send_frame(1, 0);
    pulse_start();
    send_frame(2, 0);
    for (int k = 0; k < 256; k++) begin
      send_frame(10 + k, 0);
      if (k == 0) chk("sat_first_drop", bus.drop_cnt, 1);
      if (k == 254) chk("sat_255", bus.drop_cnt, 255);
    end
    chk("sat_hold", bus.drop_cnt, 255);
    chk("sat_pulse", bus.frame_drop, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
